// File: rtl/caf_stimulus_master_if.sv
// Sample (master->CAF) and result (CAF->master) stream channels of the CAF stimulus master.
// The master modport is the stimulus side; the slave modport is the CAF core side.
interface caf_stimulus_master_if;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        m_axis_tready;

  modport master (
    output m_axis_tdata,
    output m_axis_tvalid,
    output m_axis_tready,
    input  s_axis_tready,
    input  s_axis_tdata,
    input  s_axis_tvalid
  );

  modport slave (
    input  m_axis_tdata,
    input  m_axis_tvalid,
    input  m_axis_tready,
    output s_axis_tready,
    output s_axis_tdata,
    output s_axis_tvalid
  );
endinterface

// File: rtl/caf_stimulus_master.sv
// Streams a RAM-held capture into the CAF core, then captures and reports its {index, freq} result.
// First sample valid one cycle after start; 1 sample/cycle; data held while s_axis_tready is low.
module caf_stimulus_master #(
  parameter int SAMPLE_BITS = 16,
  parameter int LENGTH      = 32,
  parameter int ADDR_BITS   = 5,
  parameter int FREQ_BITS   = 3,
  parameter int INDEX_BITS  = 5,
  parameter int TIMEOUT     = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [ADDR_BITS-1:0]   wr_addr,
  input  logic [SAMPLE_BITS-1:0] wr_data,
  input  logic                   start,
  caf_stimulus_master_if.master  axis,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [INDEX_BITS-1:0]  res_index,
  output logic [FREQ_BITS-1:0]   res_freq,
  output logic [31:0]            res_cycles
);

  localparam int WAIT_BITS = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_BITS-1:0] LAST_PTR  = ADDR_BITS'(LENGTH - 1);
  localparam logic [WAIT_BITS-1:0] WAIT_LAST = WAIT_BITS'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_DONE,
    ST_ERROR
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   rd_ptr_q, rd_ptr_d;
  logic [SAMPLE_BITS-1:0] data_q, data_d;
  logic [31:0]            cnt_q, cnt_d;
  logic [WAIT_BITS-1:0]   wait_q, wait_d;
  logic                   error_q, error_d;
  logic [INDEX_BITS-1:0]  res_index_q, res_index_d;
  logic [FREQ_BITS-1:0]   res_freq_q, res_freq_d;
  logic [31:0]            res_cycles_q, res_cycles_d;

  logic [SAMPLE_BITS-1:0] mem [LENGTH];

  logic                   wr_ok;
  logic                   xfer;
  logic                   res_acc;
  logic                   load;
  logic [ADDR_BITS-1:0]   rd_addr;
  logic [31:0]            cnt_inc;
  logic                   unused_res_hi;

  always_comb begin
    wr_ok   = wr_en && (state_q == ST_IDLE || state_q == ST_DONE);
    xfer    = (state_q == ST_SEND) && axis.s_axis_tready;
    res_acc = (state_q == ST_WAIT) && axis.s_axis_tvalid;
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 32'd1;
  end

  // Bits above the result fields are ignored.
  assign unused_res_hi = ^(axis.s_axis_tdata >> (FREQ_BITS + INDEX_BITS));

  always_comb begin
    state_d      = state_q;
    rd_ptr_d     = rd_ptr_q;
    data_d       = data_q;
    cnt_d        = cnt_q;
    wait_d       = wait_q;
    error_d      = error_q;
    res_index_d  = res_index_q;
    res_freq_d   = res_freq_q;
    res_cycles_d = res_cycles_q;
    load         = 1'b0;
    rd_addr      = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_SEND;
          rd_ptr_d = '0;
          cnt_d    = '0;
          error_d  = 1'b0;
          load     = 1'b1;
          rd_addr  = '0;
        end
      end
      ST_SEND: begin
        cnt_d  = cnt_inc;
        wait_d = '0;
        if (xfer) begin
          if (rd_ptr_q == LAST_PTR) begin
            state_d = ST_WAIT;
          end else begin
            // Fetch the next sample on the accepting edge so beats can go back to back.
            rd_ptr_d = rd_ptr_q + 1'b1;
            load     = 1'b1;
            rd_addr  = rd_ptr_q + 1'b1;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_inc;
        if (res_acc) begin
          res_index_d  = axis.s_axis_tdata[FREQ_BITS +: INDEX_BITS];
          res_freq_d   = axis.s_axis_tdata[FREQ_BITS-1:0];
          res_cycles_d = cnt_inc;
          state_d      = ST_DONE;
        end else if (wait_q == WAIT_LAST) begin
          error_d = 1'b1;
          state_d = ST_ERROR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // A write landing on the same cycle as the first fetch is forwarded.
    if (load) begin
      data_d = (wr_ok && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rd_ptr_q     <= '0;
      data_q       <= '0;
      cnt_q        <= '0;
      wait_q       <= '0;
      error_q      <= 1'b0;
      res_index_q  <= '0;
      res_freq_q   <= '0;
      res_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      wait_q       <= wait_d;
      error_q      <= error_d;
      res_index_q  <= res_index_d;
      res_freq_q   <= res_freq_d;
      res_cycles_q <= res_cycles_d;
    end
  end

  assign axis.m_axis_tdata  = 32'(data_q);
  assign axis.m_axis_tvalid = (state_q == ST_SEND);
  assign axis.m_axis_tready = (state_q == ST_WAIT);
  assign busy               = (state_q == ST_SEND) || (state_q == ST_WAIT);
  assign done               = (state_q == ST_DONE);
  assign error              = error_q;
  assign res_index          = res_index_q;
  assign res_freq           = res_freq_q;
  assign res_cycles         = res_cycles_q;

endmodule
